// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller with variable-latency memory wait,
// timeout abort and saturating stall/flush performance counters.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic              ClearCnt,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemAbortM,
  output logic              TimeoutErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             terr_q;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  logic [1:0] fa, fb;
  logic       lw_stall;
  logic       abort;
  logic       mem_stall;

  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
    if (FWD_EN != 0) begin
      if (RegWriteM && RdM != '0 && RdM == Rs1E)
        fa = 2'b10;
      else if (RegWriteW && RdW != '0 && RdW == Rs1E)
        fa = 2'b01;
      if (RegWriteM && RdM != '0 && RdM == Rs2E)
        fb = 2'b10;
      else if (RegWriteW && RdW != '0 && RdW == Rs2E)
        fb = 2'b01;
    end
  end

  // Without forwarding any in-flight writer of a D source must drain first.
  always_comb begin
    if (FWD_EN != 0) begin
      lw_stall = ResultSrcE0 && RdE != '0 &&
                 (RdE == Rs1D || RdE == Rs2D);
    end else begin
      lw_stall =
        (Rs1D != '0 &&
         ((RegWriteE && RdE == Rs1D) ||
          (RegWriteM && RdM == Rs1D))) ||
        (Rs2D != '0 &&
         ((RegWriteE && RdE == Rs2D) ||
          (RegWriteM && RdM == Rs2D)));
    end
  end

  assign abort = state_q == WAIT &&
                 wcnt_q == WW'(TIMEOUT) && !MemReadyM;
  assign mem_stall = MemReqM && !MemReadyM && !abort;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_stall) begin
          state_d = WAIT;
          wcnt_d  = WW'(1);
        end
      end
      WAIT: begin
        if (MemReadyM || abort) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemAbortM = 1'b0;
    if (!rst) begin
      ForwardAE = fa;
      ForwardBE = fb;
      MemAbortM = abort;
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (ClearCnt) begin
      scnt_d = '0;
      fcnt_d = '0;
    end else begin
      if (StallF && scnt_q != '1)
        scnt_d = scnt_q + CNT_W'(1);
      if (FlushD && fcnt_q != '1)
        fcnt_d = fcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_q | abort;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign TimeoutErr = terr_q;
  assign StallCnt   = scnt_q;
  assign FlushCnt   = fcnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: forwarding/stall vector table plus
// memory-wait, timeout, reset and counter-saturation sequences.
module tb_hazard_unit_mc;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, lde, pcs, req, rdy, clr;
  } in_t;

  typedef struct {
    int         dut;
    int         id;
    logic [1:0] fa, fb;
    logic [3:0] stl;
    logic [2:0] fl;
    logic       ab, te, cc;
    logic [3:0] sc, fc;
  } ex_t;

  typedef struct {
    in_t i;
    ex_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       ResultSrcE0, PCSrcE, MemReqM, MemReadyM, ClearCnt;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic       sF0, sD0, sE0, sM0, fD0, fE0, fW0, ab0, te0;
  logic       sF1, sD1, sE1, sM1, fD1, fE1, fW1, ab1, te1;
  logic [3:0] sc0, fc0, sc1, fc1;

  hazard_unit_mc #(
    .REG_AW(5), .FWD_EN(1), .TIMEOUT(4), .CNT_W(4)
  ) u0 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ClearCnt(ClearCnt),
    .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sF0), .StallD(sD0), .StallE(sE0), .StallM(sM0),
    .FlushD(fD0), .FlushE(fE0), .FlushW(fW0),
    .MemAbortM(ab0), .TimeoutErr(te0),
    .StallCnt(sc0), .FlushCnt(fc0)
  );

  hazard_unit_mc #(
    .REG_AW(5), .FWD_EN(0), .TIMEOUT(4), .CNT_W(4)
  ) u1 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ClearCnt(ClearCnt),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sF1), .StallD(sD1), .StallE(sE1), .StallM(sM1),
    .FlushD(fD1), .FlushE(fE1), .FlushW(fW1),
    .MemAbortM(ab1), .TimeoutErr(te1),
    .StallCnt(sc1), .FlushCnt(fc1)
  );

  ex_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  step  = 0;

  function automatic in_t nop();
    in_t i;
    i.rst = 0;
    i.rs1d = 0; i.rs2d = 0; i.rs1e = 0; i.rs2e = 0;
    i.rde = 0; i.rdm = 0; i.rdw = 0;
    i.rwe = 0; i.rwm = 0; i.rww = 0; i.lde = 0;
    i.pcs = 0; i.req = 0; i.rdy = 0; i.clr = 0;
    return i;
  endfunction

  function automatic ex_t E(int d, logic [1:0] fa,
                            logic [1:0] fb, logic [3:0] stl,
                            logic [2:0] fl);
    ex_t e;
    e.dut = d; e.id = 0;
    e.fa = fa; e.fb = fb; e.stl = stl; e.fl = fl;
    e.ab = 0; e.te = 0; e.cc = 0; e.sc = 0; e.fc = 0;
    return e;
  endfunction

  function automatic ex_t C(ex_t e, logic [3:0] sc,
                            logic [3:0] fc);
    ex_t r;
    r = e;
    r.cc = 1; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic check();
    ex_t        e;
    logic [13:0] act, exp;
    logic [3:0]  sc, fc;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: no expected entry");
      return;
    end
    e = q.pop_front();
    if (e.dut == 0) begin
      act = {fa0, fb0, sF0, sD0, sE0, sM0,
             fD0, fE0, fW0, ab0, te0};
      sc = sc0; fc = fc0;
    end else begin
      act = {fa1, fb1, sF1, sD1, sE1, sM1,
             fD1, fE1, fW1, ab1, te1};
      sc = sc1; fc = fc1;
    end
    exp = {e.fa, e.fb, e.stl, e.fl, e.ab, e.te};
    if (act !== exp ||
        (e.cc && (sc !== e.sc || fc !== e.fc))) begin
      n_bad++;
      $display("FAIL step%0d dut%0d: got outs=%b sc=%0d fc=%0d, want outs=%b sc=%0d fc=%0d (cnt checked=%0b)",
               e.id, e.dut, act, sc, fc, exp, e.sc, e.fc, e.cc);
    end
  endtask

  task automatic drive(input in_t i, input ex_t e);
    ex_t x;
    rst = i.rst;
    Rs1D = i.rs1d; Rs2D = i.rs2d;
    Rs1E = i.rs1e; Rs2E = i.rs2e;
    RdE = i.rde; RdM = i.rdm; RdW = i.rdw;
    RegWriteE = i.rwe; RegWriteM = i.rwm;
    RegWriteW = i.rww; ResultSrcE0 = i.lde;
    PCSrcE = i.pcs; MemReqM = i.req;
    MemReadyM = i.rdy; ClearCnt = i.clr;
    x = e;
    x.id = step;
    step++;
    q.push_back(x);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_t i;
    i = nop();
    i.rst = 1;
    drive(i, C(E(0, 0, 0, 0, 0), 0, 0));
  endtask

  initial begin
    vec_t tv[$];
    vec_t v;
    in_t  i;
    ex_t  e;

    rst = 1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW} = '0;
    {ResultSrcE0, PCSrcE, MemReqM, MemReadyM, ClearCnt} = '0;

    v.i = nop(); v.i.rdm = 5; v.i.rdw = 5; v.i.rs1e = 5;
    v.i.rwm = 1; v.i.rww = 1;
    v.e = E(0, 2'b10, 2'b00, 4'b0000, 3'b000); tv.push_back(v);
    v.i.rdm = 0;
    v.e = E(0, 2'b01, 2'b00, 4'b0000, 3'b000); tv.push_back(v);
    v.i.rdm = 5; v.i.rs1e = 0;
    v.e = E(0, 2'b00, 2'b00, 4'b0000, 3'b000); tv.push_back(v);
    v.i = nop(); v.i.rs2e = 9; v.i.rdm = 9; v.i.rdw = 9;
    v.i.rww = 1;
    v.e = E(0, 2'b00, 2'b01, 4'b0000, 3'b000); tv.push_back(v);
    v.i.rwm = 1;
    v.e = E(0, 2'b00, 2'b10, 4'b0000, 3'b000); tv.push_back(v);
    v.i = nop(); v.i.lde = 1; v.i.rde = 3; v.i.rs2d = 3;
    v.e = E(0, 2'b00, 2'b00, 4'b1100, 3'b010); tv.push_back(v);
    v.i = nop(); v.i.lde = 1; v.i.rde = 0; v.i.rs1d = 0;
    v.e = E(0, 2'b00, 2'b00, 4'b0000, 3'b000); tv.push_back(v);
    v.i = nop(); v.i.lde = 1; v.i.rde = 3; v.i.rs2d = 3;
    v.i.pcs = 1;
    v.e = E(0, 2'b00, 2'b00, 4'b0000, 3'b110); tv.push_back(v);
    v.i = nop(); v.i.pcs = 1;
    v.e = E(0, 2'b00, 2'b00, 4'b0000, 3'b110); tv.push_back(v);
    v.i = nop(); v.i.rwm = 1; v.i.rdm = 7; v.i.rs1d = 7;
    v.i.rs1e = 7;
    v.e = E(1, 2'b00, 2'b00, 4'b1100, 3'b010); tv.push_back(v);
    v.e = E(0, 2'b10, 2'b00, 4'b0000, 3'b000); tv.push_back(v);
    v.i = nop(); v.i.rwe = 1; v.i.rde = 4; v.i.rs2d = 4;
    v.e = E(1, 2'b00, 2'b00, 4'b1100, 3'b010); tv.push_back(v);
    v.i = nop(); v.i.rwm = 1; v.i.rdm = 0; v.i.rs1d = 0;
    v.e = E(1, 2'b00, 2'b00, 4'b0000, 3'b000); tv.push_back(v);

    @(posedge clk); #1;
    do_reset();
    foreach (tv[k]) drive(tv[k].i, tv[k].e);

    // memory wait: ready in 4th cycle
    do_reset();
    i = nop(); i.req = 1;
    for (int k = 0; k < 3; k++)
      drive(i, E(0, 0, 0, 4'b1111, 3'b001));
    i.rdy = 1;
    drive(i, E(0, 0, 0, 4'b0000, 3'b000));
    drive(nop(), C(E(0, 0, 0, 0, 0), 3, 0));

    // memory wait with branch held
    do_reset();
    i = nop(); i.req = 1; i.pcs = 1;
    for (int k = 0; k < 3; k++)
      drive(i, E(0, 0, 0, 4'b1111, 3'b001));
    i.rdy = 1;
    drive(i, E(0, 0, 0, 4'b0000, 3'b110));
    drive(nop(), C(E(0, 0, 0, 0, 0), 3, 1));

    // zero-wait request
    i = nop(); i.req = 1; i.rdy = 1;
    drive(i, C(E(0, 0, 0, 0, 0), 3, 1));

    // timeout
    do_reset();
    i = nop(); i.req = 1;
    for (int k = 0; k < 4; k++)
      drive(i, E(0, 0, 0, 4'b1111, 3'b001));
    e = E(0, 0, 0, 0, 0); e.ab = 1;
    drive(i, e);
    e = E(0, 0, 0, 0, 0); e.te = 1;
    drive(nop(), e);
    e = E(0, 0, 0, 4'b1111, 3'b001); e.te = 1;
    drive(i, e);

    // reset mid-WAIT
    do_reset();
    i = nop(); i.req = 1;
    drive(i, E(0, 0, 0, 4'b1111, 3'b001));
    drive(i, E(0, 0, 0, 4'b1111, 3'b001));
    i.rst = 1; i.pcs = 1; i.rs1e = 5; i.rdm = 5; i.rwm = 1;
    drive(i, C(E(0, 0, 0, 0, 0), 0, 0));
    i = nop(); i.req = 1;
    drive(i, E(0, 0, 0, 4'b1111, 3'b001));
    i.rdy = 1;
    drive(i, C(E(0, 0, 0, 0, 0), 1, 0));

    // saturation and clear
    do_reset();
    i = nop(); i.lde = 1; i.rde = 3; i.rs2d = 3;
    for (int k = 0; k < 20; k++)
      drive(i, E(0, 0, 0, 4'b1100, 3'b010));
    drive(i, C(E(0, 0, 0, 4'b1100, 3'b010), 15, 0));
    i.clr = 1;
    drive(i, C(E(0, 0, 0, 4'b1100, 3'b010), 15, 0));
    i.clr = 0;
    drive(i, C(E(0, 0, 0, 4'b1100, 3'b010), 0, 0));
    drive(nop(), C(E(0, 0, 0, 0, 0), 1, 0));

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: %0d entries remain, want 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It is the successor of the single-cycle-memory hazard unit and adds the following:
- a variable-latency data-memory handshake that freezes F/D/E/M and bubbles W;
- a timeout/abort state machine;
- an optional no-forwarding mode;
- saturating stall/flush performance counters.

It sits beside the pipeline stages and drives their stall, flush and forward-select inputs.

## Interface
- REG_AW, 5: register address width.
- FWD_EN, 1: 1 = M/W→E forwarding; 0 = no forwarding, RAW resolved by stalling.
- TIMEOUT, 64: maximum memory wait cycles before abort (≥2).
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- Rs1D, Rs2D  in  REG_AW  decode source registers.
- Rs1E, Rs2E, RdE  in  REG_AW  execute source and destination registers.
- RdM, RdW  in  REG_AW  memory and writeback destination registers.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- ResultSrcE0  in  1  instruction in E is a load.
- PCSrcE  in  1  branch/jump taken in E.
- MemReqM  in  1  load/store in M requests memory.
- MemReadyM  in  1  memory completes the request this cycle.
- ClearCnt  in  1  synchronous counter clear.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold the stage register.
- FlushD, FlushE, FlushW  out  1  insert a bubble.
- MemAbortM  out  1  memory request abandoned this cycle.
- TimeoutErr  out  1  sticky; set after any abort.
- StallCnt, FlushCnt  out  CNT_W  performance counters.

## Operation
- **Forwarding (FWD_EN=1)**
  - ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - With FWD_EN=0, both are constant 00.
- **Load-use (FWD_EN=1):** LwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- **RAW stall (FWD_EN=0):** LwStall = match of Rs1D or Rs2D (≠0) against RdE with RegWriteE, or against RdM with RegWriteM.
- **MemStall:** MemReqM & ~MemReadyM & ~MemAbortM.
- **FSM states IDLE, WAIT.** WaitCnt (⌈log2 TIMEOUT⌉+1 bits) counts stalled cycles.
  - IDLE: if MemStall, go to WAIT with WaitCnt=1.
  - WAIT, MemReadyM: go to IDLE, WaitCnt=0.
  - WAIT, WaitCnt==TIMEOUT and not ready: MemAbortM=1 combinationally, MemStall is deasserted, go to IDLE, TimeoutErr←1.
  - WAIT, otherwise: WaitCnt++.
  - MemAbortM is only ever 1 in WAIT.
- **Output priority (highest first):**
  1. MemStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. PCSrcE is ignored and takes effect in the release cycle.
  2. PCSrcE: FlushD=1, FlushE=1. Branch flush also overrides LwStall.
  3. LwStall: StallF=StallD=1, FlushE=1.
  4. Otherwise: all stall and flush outputs are 0.
- **Counters**
  - StallCnt increments on each cycle with StallF=1.
  - FlushCnt increments on each cycle where PCSrcE takes effect (FlushD=1).
  - Both saturate at 2^CNT_W−1.
  - ClearCnt zeroes both and takes priority over increment.
- **Reset (asynchronous):** state=IDLE, WaitCnt=0, TimeoutErr=0, StallCnt=FlushCnt=0.
  - While rst is high, all stall, flush and abort outputs are forced to 0 and ForwardAE/ForwardBE to 00.
  - rst asserted mid-WAIT returns to IDLE immediately.

## Timing
- Forward, stall, flush and MemAbortM are combinational from the current inputs and state, valid in the same cycle; there are no added pipeline stages.
- State, WaitCnt, TimeoutErr and the counters update on the rising clk edge.
- A memory request with N wait cycles (MemReadyM first high in cycle N+1) produces exactly N stall cycles and N FlushW bubbles.
- A zero-wait request (MemReadyM high with MemReqM) causes no stall.
- Abort occurs in the cycle after TIMEOUT stalled cycles, so the maximum stall is TIMEOUT cycles.
- TimeoutErr is visible the cycle after MemAbortM and clears only on rst.

## Test plan
- **Forwarding:** RdM=RdW=Rs1E=5, both RegWrite=1 → ForwardAE=10. Same with RdM=0 → ForwardAE=01. With Rs1E=0 → ForwardAE=00.
- **Load-use:** ResultSrcE0=1, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle. With PCSrcE=1 in the same cycle → FlushD=FlushE=1 and StallF=0.
- **Memory wait:** MemReqM=1, MemReadyM high in the 4th cycle → stalls plus FlushW for 3 cycles; StallCnt=3 and FlushCnt=0. PCSrcE held high throughout → FlushD appears only in the release cycle and FlushCnt=1.
- **Timeout:** TIMEOUT=4, MemReadyM never asserted → 4 stall cycles, then MemAbortM=1 for one cycle, TimeoutErr=1 on the following cycle, FSM back in IDLE.
- **FWD_EN=0:** RegWriteM=1, RdM=7, Rs1D=7 → StallF=StallD=FlushE=1 and ForwardAE stays 00.
- **Reset and clear:** rst pulsed mid-WAIT with WaitCnt=2 → all outputs 0 immediately, counters 0. Separately, a counter preloaded to all-ones via long stall holds its value; ClearCnt → 0 next edge.
